// File: rtl/btn_input_bank.sv
// btn_input_bank: per-channel button conditioner. Each channel goes
// through a 2-flop synchroniser, a stable-count debouncer, press/release
// edge pulses and an optional hold-to-repeat press generator.
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   btn_raw       [N_CH] raw bouncing button pins
//   repeat_en     [N_CH] hold-to-repeat enable per channel
//   btn_level     [N_CH] debounced level
//   btn_press     [N_CH] pulse on debounced rise and on each repeat
//   btn_is_repeat [N_CH] marks a btn_press pulse as a repeat
//   btn_release   [N_CH] pulse on debounced fall
module btn_input_bank #(
    parameter int N_CH          = 5,
    parameter int STABLE_CYCLES = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_raw,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_is_repeat,
    output logic [N_CH-1:0] btn_release
);

    localparam int DB_W =
        (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int REP_MAX =
        (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W =
        (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    localparam logic [DB_W-1:0] DB_LAST =
        DB_W'(STABLE_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST =
        REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST =
        REP_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_REPEAT
    } repState_t;

    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : gCh
        logic [DB_W-1:0]  dbCnt;
        logic             level;
        logic             flip;
        logic             riseEv;
        logic             fallEv;
        repState_t        state;
        repState_t        stateNext;
        logic [REP_W-1:0] holdCnt;
        logic [REP_W-1:0] holdNext;
        logic             pressQ;
        logic             pressNext;
        logic             isRepQ;
        logic             isRepNext;
        logic             relQ;
        logic             relNext;

        // flip is the edge on which the debounced level toggles
        assign flip   = (sync2[gi] != level) && (dbCnt == DB_LAST);
        assign riseEv = flip && !level;
        assign fallEv = flip && level;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dbCnt <= '0;
                level <= 1'b0;
            end else if (sync2[gi] == level) begin
                dbCnt <= '0;
            end else if (flip) begin
                level <= ~level;
                dbCnt <= '0;
            end else begin
                dbCnt <= dbCnt + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= ST_IDLE;
                holdCnt <= '0;
                pressQ  <= 1'b0;
                isRepQ  <= 1'b0;
                relQ    <= 1'b0;
            end else begin
                state   <= stateNext;
                holdCnt <= holdNext;
                pressQ  <= pressNext;
                isRepQ  <= isRepNext;
                relQ    <= relNext;
            end
        end

        // Debounced edges take priority over repeat timing; while
        // repeat_en is low the hold counter is parked at zero so a
        // re-enable restarts the full delay.
        always_comb begin
            stateNext = state;
            holdNext  = holdCnt;
            pressNext = 1'b0;
            isRepNext = 1'b0;
            relNext   = 1'b0;
            if (fallEv) begin
                stateNext = ST_IDLE;
                holdNext  = '0;
                relNext   = 1'b1;
            end else if (riseEv) begin
                stateNext = ST_HELD;
                holdNext  = '0;
                pressNext = 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        holdNext = '0;
                    end
                    ST_HELD: begin
                        if (!repeat_en[gi]) begin
                            holdNext = '0;
                        end else if (holdCnt == DELAY_LAST) begin
                            stateNext = ST_REPEAT;
                            holdNext  = '0;
                            pressNext = 1'b1;
                            isRepNext = 1'b1;
                        end else begin
                            holdNext = holdCnt + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!repeat_en[gi]) begin
                            stateNext = ST_HELD;
                            holdNext  = '0;
                        end else if (holdCnt == PERIOD_LAST) begin
                            holdNext  = '0;
                            pressNext = 1'b1;
                            isRepNext = 1'b1;
                        end else begin
                            holdNext = holdCnt + 1'b1;
                        end
                    end
                    default: begin
                        stateNext = ST_IDLE;
                        holdNext  = '0;
                    end
                endcase
            end
        end

        assign btn_level[gi]     = level;
        assign btn_press[gi]     = pressQ;
        assign btn_is_repeat[gi] = isRepQ;
        assign btn_release[gi]   = relQ;
    end

endmodule

// File: tb/tb_btn_input_bank.sv
// tb_btn_input_bank: scenario tasks plus randomized stimulus, checked
// every cycle against a timestamp-based reference model.
module tb_btn_input_bank;

    localparam int NCH     = 5;
    localparam int STABLE  = 4;
    localparam int RDELAY  = 10;
    localparam int RPERIOD = 3;
    localparam int MAXC    = 4096;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] btn_raw;
    logic [NCH-1:0] repeat_en;
    logic [NCH-1:0] btn_level;
    logic [NCH-1:0] btn_press;
    logic [NCH-1:0] btn_is_repeat;
    logic [NCH-1:0] btn_release;

    int passCnt;
    int totalCnt;
    int cyc;
    int t0 [NCH];

    logic [NCH-1:0] rawAt   [MAXC];
    logic [NCH-1:0] enAt    [MAXC];
    logic [NCH-1:0] levelAt [MAXC];

    btn_input_bank #(
        .N_CH         (NCH),
        .STABLE_CYCLES(STABLE),
        .REPEAT_DELAY (RDELAY),
        .REPEAT_PERIOD(RPERIOD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .repeat_en    (repeat_en),
        .btn_level    (btn_level),
        .btn_press    (btn_press),
        .btn_is_repeat(btn_is_repeat),
        .btn_release  (btn_release)
    );

    always #5 clk = ~clk;

    function automatic logic sync2At(int x, int ch);
        return (x >= 2) ? rawAt[x-2][ch] : 1'b0;
    endfunction

    // One clock: log the inputs of the current cycle, advance, then
    // derive the expected outputs of the new cycle from history.
    task automatic step();
        logic [NCH-1:0] eL, eP, eR, eRel, prevL;
        if (cyc >= MAXC - 2) begin
            $display("FAIL budget cyc=%0d limit=%0d", cyc, MAXC - 2);
            $fatal(1, "cycle budget exhausted");
        end
        rawAt[cyc] = btn_raw;
        enAt[cyc]  = repeat_en;
        @(posedge clk);
        cyc++;
        #1;
        prevL = levelAt[cyc-1];
        eL    = prevL;
        eP    = '0;
        eR    = '0;
        eRel  = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            bit flip;
            int s;
            flip = (cyc >= STABLE);
            for (int x = cyc - STABLE; x < cyc; x++)
                if (x >= 0 && (sync2At(x, ch) == prevL[ch]
                    || levelAt[x][ch] != prevL[ch]))
                    flip = 1'b0;
            eL[ch] = prevL[ch] ^ flip;
            if (eL[ch] && !prevL[ch]) begin
                t0[ch] = cyc;
                eP[ch] = 1'b1;
            end else if (!eL[ch] && prevL[ch]) begin
                eRel[ch] = 1'b1;
            end else if (eL[ch]) begin
                s = cyc;
                while (s - 1 >= t0[ch] && enAt[s-1][ch])
                    s--;
                if (cyc - s >= RDELAY
                    && (cyc - s - RDELAY) % RPERIOD == 0) begin
                    eP[ch] = 1'b1;
                    eR[ch] = 1'b1;
                end
            end
        end
        levelAt[cyc] = eL;
        totalCnt++;
        if (btn_level !== eL)
            $display("FAIL level cyc=%0d got=%b exp=%b",
                     cyc, btn_level, eL);
        else passCnt++;
        totalCnt++;
        if (btn_press !== eP)
            $display("FAIL press cyc=%0d got=%b exp=%b",
                     cyc, btn_press, eP);
        else passCnt++;
        totalCnt++;
        if (btn_is_repeat !== eR)
            $display("FAIL is_repeat cyc=%0d got=%b exp=%b",
                     cyc, btn_is_repeat, eR);
        else passCnt++;
        totalCnt++;
        if (btn_release !== eRel)
            $display("FAIL release cyc=%0d got=%b exp=%b",
                     cyc, btn_release, eRel);
        else passCnt++;
    endtask

    task automatic doReset();
        #2;
        rst_n = 1'b0;
        #1;
        totalCnt++;
        if (btn_level !== '0)
            $display("FAIL rst_level got=%b exp=0", btn_level);
        else passCnt++;
        totalCnt++;
        if (btn_press !== '0)
            $display("FAIL rst_press got=%b exp=0", btn_press);
        else passCnt++;
        totalCnt++;
        if (btn_is_repeat !== '0)
            $display("FAIL rst_is_repeat got=%b exp=0", btn_is_repeat);
        else passCnt++;
        totalCnt++;
        if (btn_release !== '0)
            $display("FAIL rst_release got=%b exp=0", btn_release);
        else passCnt++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        cyc        = 0;
        levelAt[0] = '0;
        for (int ch = 0; ch < NCH; ch++) t0[ch] = 0;
    endtask

    task automatic quiet();
        btn_raw   = '0;
        repeat_en = '0;
        repeat (10) step();
    endtask

    task automatic test_reset();
        doReset();
        repeat (6) step();
    endtask

    task automatic test_latency();
        int k;
        int pc;
        logic rp;
        quiet();
        btn_raw[0] = 1'b1;
        k  = cyc + 1;
        pc = -1;
        rp = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (btn_press[0] && pc < 0) begin
                pc = cyc;
                rp = btn_is_repeat[0];
            end
        end
        totalCnt++;
        if (pc != k + 5)
            $display("FAIL latency press_edge got=%0d exp=%0d", pc, k + 5);
        else passCnt++;
        totalCnt++;
        if (rp !== 1'b0)
            $display("FAIL latency is_repeat got=%b exp=0", rp);
        else passCnt++;
        quiet();
    endtask

    task automatic test_bounce();
        logic [3:0] pat;
        int k;
        int pc;
        int n;
        pat = 4'b0101;
        n   = 0;
        pc  = -1;
        quiet();
        for (int i = 0; i < 4; i++) begin
            btn_raw[1] = pat[i];
            repeat (2) begin
                step();
                if (btn_press[1]) n++;
            end
        end
        btn_raw[1] = 1'b1;
        k = cyc + 1;
        for (int i = 0; i < 14; i++) begin
            step();
            if (btn_press[1]) begin
                n++;
                if (pc < 0) pc = cyc;
            end
        end
        totalCnt++;
        if (n != 1)
            $display("FAIL bounce press_count got=%0d exp=1", n);
        else passCnt++;
        totalCnt++;
        if (pc != k + 5)
            $display("FAIL bounce press_edge got=%0d exp=%0d", pc, k + 5);
        else passCnt++;
        quiet();
    endtask

    // Holds channel 2 and records press offsets relative to t0.
    // enOff/enOn/relAt are offsets at which inputs change (-1 = never).
    task automatic runHold(input int enOff, input int enOn,
                           input int relAt, input int stopAt,
                           output int offs[$], output int repBad,
                           output int relCnt, output int relOff,
                           output int start);
        offs   = {};
        repBad = 0;
        relCnt = 0;
        relOff = -1;
        start  = -1;
        quiet();
        repeat_en[2] = 1'b1;
        btn_raw[2]   = 1'b1;
        for (int i = 0; i < 20 && start < 0; i++) begin
            step();
            if (btn_press[2]) start = cyc;
        end
        if (start < 0) return;
        offs.push_back(0);
        if (btn_is_repeat[2]) repBad++;
        while (cyc < start + stopAt) begin
            if (cyc == start + enOff) repeat_en[2] = 1'b0;
            if (cyc == start + enOn)  repeat_en[2] = 1'b1;
            if (cyc == start + relAt) btn_raw[2]   = 1'b0;
            step();
            if (btn_press[2]) begin
                offs.push_back(cyc - start);
                if (btn_is_repeat[2] !== 1'b1) repBad++;
            end
            if (btn_release[2]) begin
                relCnt++;
                relOff = cyc - start;
            end
        end
        quiet();
    endtask

    task automatic test_repeat();
        int offs[$];
        int repBad, relCnt, relOff, start, e;
        runHold(-1, -1, 17, 45, offs, repBad, relCnt, relOff, start);
        totalCnt++;
        if (offs.size() != 6)
            $display("FAIL repeat count got=%0d exp=6", offs.size());
        else passCnt++;
        for (int j = 0; j < offs.size() && j < 6; j++) begin
            e = (j == 0) ? 0 : RDELAY + (j - 1) * RPERIOD;
            totalCnt++;
            if (offs[j] != e)
                $display("FAIL repeat pulse%0d got=%0d exp=%0d",
                         j, offs[j], e);
            else passCnt++;
        end
        totalCnt++;
        if (repBad != 0)
            $display("FAIL repeat flag_errors got=%0d exp=0", repBad);
        else passCnt++;
        totalCnt++;
        if (relCnt != 1 || relOff != 23)
            $display("FAIL repeat release got=%0d@%0d exp=1@23",
                     relCnt, relOff);
        else passCnt++;
    endtask

    task automatic test_repeat_disable();
        int offs[$];
        int want[5];
        int repBad, relCnt, relOff, start;
        want = '{0, 10, 30, 33, 36};
        runHold(11, 20, 31, 50, offs, repBad, relCnt, relOff, start);
        totalCnt++;
        if (offs.size() != 5)
            $display("FAIL disable count got=%0d exp=5", offs.size());
        else passCnt++;
        for (int j = 0; j < offs.size() && j < 5; j++) begin
            totalCnt++;
            if (offs[j] != want[j])
                $display("FAIL disable pulse%0d got=%0d exp=%0d",
                         j, offs[j], want[j]);
            else passCnt++;
        end
        totalCnt++;
        if (repBad != 0)
            $display("FAIL disable flag_errors got=%0d exp=0", repBad);
        else passCnt++;
    endtask

    task automatic test_reset_mid();
        int start;
        int pc;
        logic rp;
        quiet();
        repeat_en[3] = 1'b1;
        btn_raw[3]   = 1'b1;
        start = -1;
        for (int i = 0; i < 20 && start < 0; i++) begin
            step();
            if (btn_press[3]) start = cyc;
        end
        while (start >= 0 && cyc < start + RDELAY + RPERIOD)
            step();
        doReset();
        pc = -1;
        rp = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (btn_press[3] && pc < 0) begin
                pc = cyc;
                rp = btn_is_repeat[3];
            end
        end
        totalCnt++;
        if (pc != 6)
            $display("FAIL reset_mid press_edge got=%0d exp=6", pc);
        else passCnt++;
        totalCnt++;
        if (rp !== 1'b0)
            $display("FAIL reset_mid is_repeat got=%b exp=0", rp);
        else passCnt++;
        quiet();
    endtask

    task automatic test_simultaneous();
        logic [NCH-1:0] gotP, gotR, wantR;
        wantR = '0;
        wantR[NCH-1] = 1'b1;
        quiet();
        btn_raw = '1;
        gotP = '0;
        for (int i = 0; i < 12 && gotP == '0; i++) begin
            step();
            gotP = btn_press;
        end
        totalCnt++;
        if (gotP !== '1)
            $display("FAIL simul press got=%b exp=%b", gotP, {NCH{1'b1}});
        else passCnt++;
        repeat (3) step();
        btn_raw[NCH-1] = 1'b0;
        gotR = '0;
        for (int i = 0; i < 12 && gotR == '0; i++) begin
            step();
            gotR = btn_release;
        end
        totalCnt++;
        if (gotR !== wantR)
            $display("FAIL simul release got=%b exp=%b", gotR, wantR);
        else passCnt++;
        quiet();
    endtask

    task automatic test_random();
        int left [NCH];
        int idx;
        for (int ch = 0; ch < NCH; ch++)
            left[ch] = $urandom_range(1, 25);
        repeat_en = NCH'($urandom);
        for (int i = 0; i < 1500; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                left[ch]--;
                if (left[ch] <= 0) begin
                    btn_raw[ch] = ~btn_raw[ch];
                    left[ch] = $urandom_range(1, 30);
                end
            end
            if ($urandom_range(0, 15) == 0) begin
                idx = $urandom_range(0, NCH - 1);
                repeat_en[idx] = ~repeat_en[idx];
            end
            if (i == 700) doReset();
            step();
        end
        quiet();
    endtask

    initial begin
        rst_n     = 1'b1;
        btn_raw   = '0;
        repeat_en = '0;
        cyc       = 0;
        passCnt   = 0;
        totalCnt  = 0;
        levelAt[0] = '0;
        for (int ch = 0; ch < NCH; ch++) t0[ch] = 0;
        test_reset();
        test_latency();
        test_bounce();
        test_repeat();
        test_repeat_disable();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/btn_input_bank.md
Name: btn_input_bank

Overview:
- Parametrised, multi-channel successor to the single-button debouncer. Player-B button inputs (btnS/btnR/btnL/btnU/btnD) feed it directly, one channel per button.
- Per channel it does four things:
  - 2-flop synchronisation of the raw pin.
  - Stable-count debouncing.
  - One-cycle press and release pulses on the clean level.
  - Optional hold-to-repeat press pulses, used for continuous player movement.
- Outputs drive the game-logic FSM at the system clock.

Parameters:
- N_CH, 5, number of independent button channels.
- STABLE_CYCLES, 500000, consecutive cycles the synchronised input must differ from btn_level before btn_level flips (5 ms at 100 MHz); must be >= 1.
- REPEAT_DELAY, 25000000, cycles from the initial press pulse to the first repeat pulse; must be >= 1.
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_raw  input  N_CH  raw, asynchronous, bouncing button pins; bit i is channel i.
- repeat_en  input  N_CH  per-channel hold-to-repeat enable; synchronous to clk; sampled every cycle.
- btn_level  output  N_CH  debounced, registered level.
- btn_press  output  N_CH  one-cycle pulse on each debounced rising edge and on each repeat event.
- btn_is_repeat  output  N_CH  high together with btn_press[i] only when that pulse is a repeat, not the initial press.
- btn_release  output  N_CH  one-cycle pulse on each debounced falling edge.

Behaviour:
- Reset:
  - rst_n low asynchronously clears all synchroniser flops, counters and outputs to 0.
  - Reset mid-press discards all state, including pending repeats.
  - If a button is held through reset release, it is treated as a fresh press: btn_press pulses after the normal debounce latency.
- Synchroniser:
  - sync1 <= btn_raw; sync2 <= sync1 (per bit).
  - Only sync2 is used downstream.
- Debounce, per channel:
  - Counter width is clog2(STABLE_CYCLES), minimum 1.
  - At each edge where sync2 == btn_level: counter <= 0.
  - At each edge where sync2 != btn_level and counter == STABLE_CYCLES-1: btn_level <= ~btn_level and counter <= 0.
  - At any other edge where they differ: counter increments.
  - Latency: the edge that captures a new raw value into sync1 is edge k; btn_level changes at edge k+STABLE_CYCLES+1.
  - Any glitch where sync2 differs for fewer than STABLE_CYCLES consecutive cycles produces no level change and no pulse.
- Edge pulses:
  - btn_press[i] is asserted for exactly the cycle in which btn_level[i] first reads 1.
  - btn_release[i] is asserted for exactly the cycle in which btn_level[i] first reads 0.
  - Both are registered and never asserted in the same cycle for one channel.
- Repeat state machine, per channel; states IDLE, HELD, REPEAT:
  - IDLE -> HELD on debounced rise; hold counter <= 0; initial press pulse with btn_is_repeat = 0.
  - HELD: hold counter increments each cycle. When repeat_en[i] is high and the counter reaches REPEAT_DELAY-1, emit btn_press + btn_is_repeat next cycle, go to REPEAT, counter <= 0.
  - REPEAT: counter increments. At REPEAT_PERIOD-1, emit a repeat pulse next cycle, counter <= 0.
  - Any state -> IDLE on debounced fall; counter cleared; no repeat pulse in the release cycle.
  - Resulting pulse schedule, with t0 the initial press cycle: t0, t0+REPEAT_DELAY, then every REPEAT_PERIOD.
- repeat_en[i] low while in HELD or REPEAT:
  - Return to HELD with counter <= 0; no further repeats.
  - Re-asserting repeat_en[i] restarts the full REPEAT_DELAY.
- Counter width for the repeat counter is clog2(max(REPEAT_DELAY, REPEAT_PERIOD)); counters never wrap.
- Channels are fully independent; simultaneous events on multiple channels produce simultaneous pulses.

Test Plan (N_CH=5, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Debounce latency: clean rise on btn_raw[0], first captured at edge k. Required: btn_level[0]=1 and btn_press[0]=1 for one cycle at edge k+5; btn_is_repeat[0]=0; other channels stay 0.
- Bounce rejection: btn_raw[1] toggles 1,0,1,0 at 2-cycle intervals, then stays 1. Required: no pulse during the bounce; exactly one btn_press[1], 5 edges after the final stable capture.
- Auto-repeat: hold btn_raw[2] with repeat_en[2]=1 and initial press at cycle t0. Required: btn_press[2] at t0, t0+10, t0+13, t0+16; btn_is_repeat[2]=1 on all but the first. On release, btn_release[2] pulses once and no further presses follow.
- Repeat disabled mid-hold: drop repeat_en[2] at t0+11. Required: no pulse at t0+13. Re-enable at t0+20 with the button still held: next repeat at t0+30.
- Reset mid-hold: pull rst_n low during a repeat burst on channel 3 with btn_raw[3] held. Required: all outputs 0 immediately. After rst_n rises, btn_press[3] pulses 5 edges after the first capture, with btn_is_repeat[3]=0.
- Simultaneous channels: all five btn_raw bits rise on the same edge. Required: btn_press=5'b11111 in one cycle. Release of channel 4 only gives btn_release=5'b10000.
